// File: rtl/shift_add_mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
package shift_add_mult_pkg;

  localparam int MULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/fourBitAdder.sv
// Four-bit ripple-carry adder; C[4] is the carry out.
module fourBitAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [4:0] C
);

  logic [4:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign C[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign C[4] = carry[4];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with valid/ready on both sides.
// Optional: define SHIFT_ADD_MULT_EARLY_EXIT_EN to stop once the remaining multiplier bits are zero.
module shift_add_multiplier
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if (WIDTH != MULT_WIDTH) begin : g_width_check
    $error("shift_add_multiplier: WIDTH must equal the adder width (4)");
  end

  mult_state_t          state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   p;
  logic [CNT_W-1:0]     cnt;

  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   p_next;
  logic [2*WIDTH-1:0]   result;
  logic                 last_iter;

  fourBitAdder u_adder (
    .A (p[2*WIDTH-1:WIDTH]),
    .B (mcand),
    .C (add_sum)
  );

  // Adder carry lands in P[2W-1] through the shift.
  assign sum    = p[0] ? add_sum : {1'b0, p[2*WIDTH-1:WIDTH]};
  assign p_next = {sum, p[WIDTH-1:1]};

`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
  logic [CNT_W-1:0] rem_bits;
  logic [WIDTH-1:0] rem_mask;

  // Look at the multiplier bits still unconsumed after this iteration; once they
  // are all zero the partial product only needs its final alignment shift.
  assign rem_bits  = LAST_CNT - cnt;
  assign rem_mask  = ~({WIDTH{1'b1}} << rem_bits);
  assign last_iter = ((p_next[WIDTH-1:0] & rem_mask) == '0);
  assign result    = p_next >> rem_bits;
`else
  assign last_iter = (cnt == LAST_CNT);
  assign result    = p_next;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: state registers use non-blocking assignments and an async reset branch
  // so every flop samples the same pre-edge values and clears without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      p       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            p     <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          p   <= p_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            product <= result;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier; honours SHIFT_ADD_MULT_EARLY_EXIT_EN.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edges from the accepting edge (inclusive) to the edge that raises out_valid.
  function automatic int exp_lat(input logic [3:0] bb);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    int h = -1;
    for (int i = 0; i < 4; i++) if (bb[i]) h = i;
    return (h < 0) ? 2 : h + 2;
`else
    return 5;
`endif
  endfunction

  task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb_v, input int hold);
    int         lat;
    logic [7:0] exp_p;
    sb_q.push_back(8'(ta) * 8'(tb_v));
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      a = 4'($urandom); b = 4'($urandom); in_valid = 1'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("out_valid_timeout", out_valid, 1);
    check("latency", lat, exp_lat(tb_v));
    exp_p = sb_q.pop_front();
    check("product", product, exp_p);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 4'($urandom); b = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_product", product, exp_p);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    check("post_product", product, exp_p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    rst = 1'b0;

    // First acceptance on the first edge after reset release.
    run_txn(4'd3, 4'd2, 0);
    run_txn(4'd15, 4'd15, 0);
    run_txn(4'd0, 4'd9, 0);
    run_txn(4'd9, 4'd0, 0);

    // Backpressure with ignored operand pulses.
    run_txn(4'd6, 4'd7, 10);

    // Reset in the middle of a calculation.
    a = 4'd7; b = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midcalc_in_ready", in_ready, 1);
    check("midcalc_out_valid", out_valid, 0);
    check("midcalc_product", product, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_txn(4'd2, 4'd3, 0);

    // Early-exit corner operands (checked against the latency model in both builds).
    run_txn(4'd7, 4'd1, 0);
    run_txn(4'd7, 4'd8, 0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_txn(4'(i), 4'(j), 0);
      end
    end

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
